vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_capture.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: captures one VGA frame at a time into a linear framebuffer.
// The input timing is registered once (S1) and edge-detected. A three-state
// FSM follows the frame timing and counts the geometry. Each pixel leaves
// as a write strobe, address and data, one register stage after S1.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cap_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    localparam int CW = 10;
    localparam int AW = 19;

    // Geometry limits at counter width (counters are 10 bits, so both
    // dimensions must stay below 1024).
    localparam logic [CW-1:0] H_LIM = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_LIM = CW'(V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // S1 input registers and the previous-cycle copies used for edge detection
    logic            r_cap_en_s1;
    logic            r_hsync_s1;
    logic            r_vsync_s1;
    logic            r_valid_s1;
    logic [23:0]     r_rgb_s1;
    logic            r_vsync_d;
    logic            r_valid_d;

    // Geometry counters and the sticky error flag
    logic [CW-1:0]   r_h_cnt;
    logic [CW-1:0]   r_v_cnt;
    logic            r_frame_err;

    // Output register stage
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [23:0]     r_wr_data;
    logic            r_frame_done;

    // Combinational next values
    logic            w_frame_start;
    logic            w_line_end;
    logic [CW-1:0]   w_h_nxt;
    logic [CW-1:0]   w_v_nxt;
    logic            w_err_nxt;
    logic            w_wr;
    logic            w_done;
    logic [CW-1:0]   w_pix_h;
    logic [CW-1:0]   w_pix_v;
    logic [AW-1:0]   w_addr;

    // Saturating increment: a counter that has reached all-ones stays there.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // Register every input once; keep the previous S1 sync/valid for edges
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cap_en_s1 <= 1'b0;
            r_hsync_s1  <= 1'b0;
            r_vsync_s1  <= 1'b0;
            r_valid_s1  <= 1'b0;
            r_rgb_s1    <= '0;
            r_vsync_d   <= 1'b0;
            r_valid_d   <= 1'b0;
        end else begin
            r_cap_en_s1 <= cap_en;
            r_hsync_s1  <= hsync;
            r_vsync_s1  <= vsync;
            r_valid_s1  <= valid;
            r_rgb_s1    <= {vga_r, vga_g, vga_b};
            r_vsync_d   <= r_vsync_s1;
            r_valid_d   <= r_valid_s1;
        end
    end

    // Frame start is the vsync falling edge; line end is the valid falling edge.
    assign w_frame_start = r_vsync_d & ~r_vsync_s1;
    assign w_line_end    = r_valid_d & ~r_valid_s1;

    // Next-state logic. A frame start always re-decides between ARMED and
    // SEARCH from cap_en, so one vsync edge closes a frame and arms the next.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEARCH: begin
                if (w_frame_start && r_cap_en_s1)
                    w_state_nxt = ARMED;
            end
            ARMED: begin
                if (w_frame_start)
                    w_state_nxt = r_cap_en_s1 ? ARMED : SEARCH;
                else if (r_valid_s1)
                    w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (w_frame_start)
                    w_state_nxt = r_cap_en_s1 ? ARMED : SEARCH;
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    // Counter, error and write decisions. Line end is resolved before the
    // frame-start check so a coincident final line still counts.
    always_comb begin
        w_h_nxt   = r_h_cnt;
        w_v_nxt   = r_v_cnt;
        w_err_nxt = r_frame_err;
        w_wr      = 1'b0;
        w_done    = 1'b0;
        w_pix_h   = r_h_cnt;
        w_pix_v   = r_v_cnt;
        case (r_state)
            ARMED: begin
                w_h_nxt   = '0;
                w_v_nxt   = '0;
                w_err_nxt = 1'b0;
                if (r_valid_s1 && !w_frame_start) begin
                    // First pixel of the frame lands at (0,0)
                    w_wr      = 1'b1;
                    w_pix_h   = '0;
                    w_pix_v   = '0;
                    w_h_nxt   = CW'(1);
                    w_err_nxt = ~r_hsync_s1;
                end
            end
            CAPTURE: begin
                if (r_valid_s1) begin
                    if (r_h_cnt < H_LIM && r_v_cnt < V_LIM)
                        w_wr = 1'b1;
                    else
                        w_err_nxt = 1'b1;
                    if (!r_hsync_s1)
                        w_err_nxt = 1'b1;
                    w_h_nxt = sat_inc(r_h_cnt);
                end
                if (w_line_end) begin
                    if (r_h_cnt != H_LIM)
                        w_err_nxt = 1'b1;
                    w_h_nxt = '0;
                    w_v_nxt = sat_inc(r_v_cnt);
                end
                if (w_frame_start) begin
                    if (w_v_nxt == V_LIM && !w_err_nxt)
                        w_done = 1'b1;
                    else
                        w_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Word address v*H_ACTIVE + h; the 640-wide case uses two shifts.
    generate
        if (H_ACTIVE == 640) begin : g_addr_shift
            assign w_addr = (AW'(w_pix_v) << 9) + (AW'(w_pix_v) << 7) + AW'(w_pix_h);
        end else begin : g_addr_mul
            assign w_addr = AW'(w_pix_v) * AW'(H_ACTIVE) + AW'(w_pix_h);
        end
    endgenerate

    // State, counters and sticky error register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= SEARCH;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_h_cnt     <= w_h_nxt;
            r_v_cnt     <= w_v_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    // Output stage: address and data only move on a real write
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en      <= w_wr;
            r_frame_done <= w_done;
            if (w_wr) begin
                r_wr_addr <= w_addr;
                r_wr_data <= r_rgb_s1;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state == CAPTURE);

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture: drives synthetic VGA frames (640 wide, 5 lines
// tall to keep runs short) and checks the write stream, frame_done and
// frame_err against a frame-level model of the capture rules.
module tb_vga_capture;

    localparam int H = 640;
    localparam int V = 5;

    logic        clk = 1'b0;
    logic        clrn;
    logic        cap_en;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .cap_en     (cap_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .valid      (valid),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int unsigned cyc;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Frame-level model state
    bit  m_cap  = 0;   // current frame is being captured
    bit  m_bad  = 0;   // error seen so far in the captured frame
    bit  m_err  = 0;   // sticky frame_err value when not capturing
    int  m_lines = 0;  // lines seen in the captured frame
    int  m_fd_exp = 0;
    int  fd_seen = 0;
    int  line_len[0:15];

    // Write-stream monitor: every write must match the next expected one,
    // including the cycle at which it appears.
    always @(negedge clk) begin
        wr_t e;
        if (frame_done === 1'b1) fd_seen++;
        if (wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr=%0d data=%0h at cyc %0d, required no write", wr_addr, wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr[18:0] || wr_data !== e.data[23:0] || cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL write: addr=%0d data=%0h cyc=%0d, required addr=%0d data=%0h cyc=%0d",
                             wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_lines(input int len);
        for (int i = 0; i < 16; i++) line_len[i] = len;
    endtask

    // Falling vsync edge: closes the current frame and decides the next one.
    task automatic do_vsync(input bit cap);
        bit exp_err;
        bit exp_done;
        tick();
        cap_en = cap;
        vsync  = 1'b0;
        exp_err  = m_cap ? (m_bad || m_lines != V) : m_err;
        exp_done = m_cap && !exp_err;
        if (exp_done) m_fd_exp++;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (frame_done !== exp_done) begin
            n_bad++;
            $display("FAIL vsync_done: frame_done=%0b, required %0b (cyc %0d)", frame_done, exp_done, cyc);
        end
        n_cmp++;
        if (frame_err !== exp_err) begin
            n_bad++;
            $display("FAIL vsync_err: frame_err=%0b, required %0b (cyc %0d)", frame_err, exp_err, cyc);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_done !== 1'b0 || frame_err !== (cap ? 1'b0 : exp_err)) begin
            n_bad++;
            $display("FAIL vsync_after: done=%0b err=%0b, required done=0 err=%0b",
                     frame_done, frame_err, cap ? 1'b0 : exp_err);
        end
        m_err   = cap ? 1'b0 : exp_err;
        m_cap   = cap;
        m_bad   = 0;
        m_lines = 0;
        tick();
        vsync = 1'b1;
        repeat ($urandom_range(3, 8)) tick();
    endtask

    // Drives nlines lines with lengths from line_len[]; optional reset,
    // cap_en drop and hsync fault before/at a chosen line (-1 = none).
    task automatic run_frame(input int nlines, input bit ramp, input int rst_line,
                             input int drop_line, input int hs_line);
        logic [31:0] pix;
        int gap;
        for (int v = 0; v < nlines; v++) begin
            if (v == drop_line) cap_en = 1'b0;
            if (v == rst_line) begin
                clrn = 1'b0;
                #1;
                n_cmp++;
                if ({wr_en, wr_addr, wr_data, frame_done, frame_err, busy} !== 46'd0 || exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL reset_mid: en=%0b addr=%0d data=%0h done=%0b err=%0b busy=%0b pending=%0d, required all 0",
                             wr_en, wr_addr, wr_data, frame_done, frame_err, busy, exp_q.size());
                end
                tick();
                clrn  = 1'b1;
                m_cap = 0;
                m_err = 0;
                m_bad = 0;
                m_lines = 0;
            end
            for (int h = 0; h < line_len[v]; h++) begin
                tick();
                valid = 1'b1;
                hsync = !(v == hs_line && h == 0);
                pix = ramp ? 32'(v * H + h) : $urandom;
                {vga_r, vga_g, vga_b} = pix[23:0];
                if (m_cap) begin
                    if (v < V && h < H) exp_q.push_back('{v * H + h, pix & 32'h00FF_FFFF, cyc + 2});
                    else m_bad = 1;
                    if (hsync == 1'b0) m_bad = 1;
                end
            end
            tick();
            valid = 1'b0;
            hsync = 1'b1;
            if (m_cap) begin
                if (line_len[v] != H) m_bad = 1;
                m_lines++;
            end
            gap = $urandom_range(4, 9);
            for (int g = 0; g < gap; g++) begin
                tick();
                hsync = !(g == 1 || g == 2);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || frame_err !== (m_cap ? m_bad : m_err) || busy !== m_cap) begin
            n_bad++;
            $display("FAIL frame_end: pending=%0d err=%0b busy=%0b, required pending=0 err=%0b busy=%0b",
                     exp_q.size(), frame_err, busy, m_cap ? m_bad : m_err, m_cap);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; cap_en = 1'b0; hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
        vga_r = 8'hAA; vga_g = 8'h55; vga_b = 8'hFF;
        repeat (4) tick();
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, frame_done, frame_err, busy} !== 46'd0) begin
            n_bad++;
            $display("FAIL reset_state: en=%0b addr=%0d data=%0h done=%0b err=%0b busy=%0b, required all 0",
                     wr_en, wr_addr, wr_data, frame_done, frame_err, busy);
        end
        clrn = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_ramp();
        set_all_lines(H);
        do_vsync(1);
        run_frame(V, 1, -1, -1, -1);
        n_cmp++;
        if (wr_addr !== 19'(V * H - 1) || wr_data !== 24'(V * H - 1)) begin
            n_bad++;
            $display("FAIL hold_last: addr=%0d data=%0d, required %0d", wr_addr, wr_data, V * H - 1);
        end
        do_vsync(1);
        run_frame(V, 1, -1, -1, -1);
        do_vsync(1);
    endtask

    task automatic test_short_line();
        set_all_lines(H);
        line_len[2] = H - 1;
        run_frame(V, 0, -1, -1, -1);
        do_vsync(1);
        set_all_lines(H);
        run_frame(V, 0, -1, -1, -1);
        do_vsync(1);
    endtask

    task automatic test_long_line();
        set_all_lines(H);
        line_len[1] = H + 2;
        run_frame(V, 1, -1, -1, -1);
        do_vsync(1);
    endtask

    task automatic test_cap_en();
        set_all_lines(H);
        run_frame(V, 0, -1, -1, -1);
        do_vsync(0);
        run_frame(V, 0, -1, -1, -1);
        do_vsync(1);
        run_frame(V, 0, -1, 2, -1);
        do_vsync(1);
    endtask

    task automatic test_reset_mid();
        set_all_lines(H);
        run_frame(V, 0, 3, -1, -1);
        do_vsync(1);
        run_frame(V, 0, -1, -1, -1);
        do_vsync(1);
    endtask

    task automatic test_line_count();
        set_all_lines(H);
        run_frame(V + 1, 0, -1, -1, -1);
        do_vsync(1);
        run_frame(V - 1, 0, -1, -1, -1);
        do_vsync(1);
    endtask

    task automatic test_hsync_fault();
        set_all_lines(H);
        run_frame(V, 0, -1, -1, 1);
        do_vsync(1);
    endtask

    task automatic test_back_to_back();
        int nl;
        for (int f = 0; f < 3; f++) begin
            set_all_lines(H);
            if ($urandom_range(0, 1) == 1) line_len[$urandom_range(0, V - 1)] = H + ($urandom_range(0, 1) == 1 ? 1 : -2);
            nl = V + $urandom_range(0, 2) - 1;
            run_frame(nl, 0, -1, -1, -1);
            do_vsync(1'($urandom_range(0, 3) != 0));
        end
        set_all_lines(H);
        run_frame(V, 0, -1, -1, -1);
        do_vsync(1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_short_line();
        test_long_line();
        test_cap_en();
        test_reset_mid();
        test_line_count();
        test_hsync_fault();
        test_back_to_back();
        repeat (4) tick();
        n_cmp++;
        if (fd_seen != m_fd_exp || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL totals: frame_done pulses=%0d pending=%0d, required pulses=%0d pending=0",
                     fd_seen, exp_q.size(), m_fd_exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
